// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: instruction kinds, major opcodes and an
// immediate range helper used by the packer.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_LOAD   = 3'd1,
    KIND_OPIMM  = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JAL    = 3'd5,
    KIND_LUI    = 3'd6,
    KIND_JALR   = 3'd7
  } kind_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // True when imm[31:msb] are all equal, i.e. the value survives truncation
  // to a signed field whose sign bit is at position msb.
  function automatic logic sext_ok(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit RV32I word for one request
// and flags immediates that do not fit the selected format.
module instr_pack (
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_bad
);
  import rv_isa_pkg::*;

  // Select the bit layout for the instruction kind and range-check the immediate.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    word    = '0;
    imm_bad = 1'b0;
    case (kind_e'(kind))
      KIND_R: word = {funct7, rs2, rs1, funct3, rd, OP_R};
      KIND_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        imm_bad = !sext_ok(imm, 11);
      end
      KIND_OPIMM: begin
        // Shift-immediates carry funct7 in the top bits and a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {funct7, imm[4:0], rs1, funct3, rd, OP_OPIMM};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
        imm_bad = !sext_ok(imm, 11);
      end
      KIND_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        imm_bad = !sext_ok(imm, 11);
      end
      KIND_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        imm_bad = !sext_ok(imm, 12) || imm[0];
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        imm_bad = !sext_ok(imm, 20) || imm[0];
      end
      KIND_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        imm_bad = (imm[11:0] != 12'h000);
      end
      KIND_JALR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        imm_bad = !sext_ok(imm, 11);
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one instruction description at a time, packs it
// into an RV32I word and writes it to consecutive words of instruction memory.
// Optional build macro ENC_IMM_CHECK_EN: reject out-of-range immediates with an
// err pulse instead of silently truncating them.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 kind,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  input  logic                       flush,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);
  import rv_isa_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    word_q, word_d;
  logic           started_q;
  logic [31:0]    pack_word;
  logic           pack_bad;
  logic           accept;
  logic           reject;

  instr_pack u_pack (
    .kind    (kind),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (pack_word),
    .imm_bad (pack_bad)
  );

  // A flush in IDLE wins over a simultaneous request.
  assign accept = (state_q == IDLE) && in_valid && in_ready && !flush;

`ifdef ENC_IMM_CHECK_EN
  logic bad_q, bad_d;

  // Remember whether the accepted request had an unencodable immediate.
  always_comb begin
    bad_d = accept ? pack_bad : bad_q;
  end

  // Reject flag register, captured alongside the encoded word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bad_q <= 1'b0;
    else     bad_q <= bad_d;
  end

  assign reject = bad_q;
`else
  logic unused_imm_bad;
  assign unused_imm_bad = pack_bad;
  assign reject         = 1'b0;
`endif

  // Next-state, write-pointer and captured-word logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          count_d = '0;
        end else if (accept) begin
          word_d  = pack_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (!reject) begin
          count_d = count_q + CW'(1);
          if (!flush && count_q == CW'(DEPTH - 1)) state_d = FULL;
        end
        // The write in this cycle still happens; only the pointer restarts.
        if (flush) count_d = '0;
      end
      FULL: begin
        if (flush) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; started_q holds off in_ready until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      // NOTE: word_q is a single control-path register feeding mem_wdata, so it is reset to give a defined 0 out of reset.
      word_q    <= '0;
      started_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      word_q    <= word_d;
      started_q <= 1'b1;
    end
  end

  assign in_ready  = (state_q == IDLE) && started_q;
  assign mem_we    = (state_q == WRITE) && !reject;
  assign err       = (state_q == WRITE) && reject;
  assign mem_addr  = BASE_ADDR + (32'(count_q) << 2);
  assign mem_wdata = word_q;
  assign full      = (state_q == FULL);
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a 256-word instance at base 0 and a
// 2-word instance at base 0x100. Expected writes are queued as requests are
// driven and popped by a negedge monitor when mem_we is seen.
module tb_instr_encoder;
  import rv_isa_pkg::*;

  localparam logic [31:0] BASE_A = 32'h0;
  localparam logic [31:0] BASE_B = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        in_valid_a, flush_a, in_ready_a, mem_we_a, full_a, err_a;
  logic [31:0] mem_addr_a, mem_wdata_a;
  logic [8:0]  count_a;
  logic        in_valid_b, flush_b, in_ready_b, mem_we_b, full_b, err_b;
  logic [31:0] mem_addr_b, mem_wdata_b;
  logic [1:0]  count_b;

  instr_encoder #(.BASE_ADDR(BASE_A), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .flush(flush_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .full(full_a), .count(count_a), .err(err_a)
  );

  instr_encoder #(.BASE_ADDR(BASE_B), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .flush(flush_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .full(full_b), .count(count_b), .err(err_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int  exp_cnt_a = 0;
  int  exp_cnt_b = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic logic cur_ready(input int which);
    return (which == 0) ? in_ready_a : in_ready_b;
  endfunction

  // Checks every write against the queue and that in_ready is low during it.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_we_a) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_bad++;
          $display("FAIL write_a_unexpected: addr=%h data=%h, required no write", mem_addr_a, mem_wdata_a);
        end else begin
          e = q_a.pop_front();
          if (mem_addr_a !== e.addr || mem_wdata_a !== e.data) begin
            n_bad++;
            $display("FAIL write_a: got %h@%h, required %h@%h", mem_wdata_a, mem_addr_a, e.data, e.addr);
          end
        end
        n_cmp++;
        if (in_ready_a !== 1'b0) begin
          n_bad++;
          $display("FAIL ready_in_write_a: in_ready=%b, required 0", in_ready_a);
        end
      end
      if (!rst && mem_we_b) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_bad++;
          $display("FAIL write_b_unexpected: addr=%h data=%h, required no write", mem_addr_b, mem_wdata_b);
        end else begin
          e = q_b.pop_front();
          if (mem_addr_b !== e.addr || mem_wdata_b !== e.data) begin
            n_bad++;
            $display("FAIL write_b: got %h@%h, required %h@%h", mem_wdata_b, mem_addr_b, e.data, e.addr);
          end
        end
        n_cmp++;
        if (in_ready_b !== 1'b0) begin
          n_bad++;
          $display("FAIL ready_in_write_b: in_ready=%b, required 0", in_ready_b);
        end
      end
    end
  endtask

  // Waits (bounded) for in_ready, presents one request for one cycle and
  // optionally queues the write it must produce. Returns in the cycle after acceptance.
  task automatic send(input int which, input logic [2:0] k, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic [31:0] word,
                      input bit push);
    int guard = 0;
    while (cur_ready(which) !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cur_ready(which) !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout_%0d: in_ready=%b, required 1", which, cur_ready(which));
      return;
    end
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    if (which == 0) begin
      in_valid_a = 1'b1;
      if (push) begin
        q_a.push_back('{addr: BASE_A + 32'(exp_cnt_a * 4), data: word});
        exp_cnt_a++;
      end
    end else begin
      in_valid_b = 1'b1;
      if (push) begin
        q_b.push_back('{addr: BASE_B + 32'(exp_cnt_b * 4), data: word});
        exp_cnt_b++;
      end
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Waits (bounded) for all queued writes to appear, then checks count.
  task automatic drain(input int which);
    int guard = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (((which == 0) ? q_a.size() : q_b.size()) != 0) begin
      n_bad++;
      $display("FAIL drain_timeout_%0d: %0d writes missing, required 0", which,
               (which == 0) ? q_a.size() : q_b.size());
    end
    n_cmp++;
    if (which == 0 && count_a !== 9'(exp_cnt_a)) begin
      n_bad++;
      $display("FAIL count_a: got %0d, required %0d", count_a, exp_cnt_a);
    end else if (which == 1 && count_b !== 2'(exp_cnt_b)) begin
      n_bad++;
      $display("FAIL count_b: got %0d, required %0d", count_b, exp_cnt_b);
    end
  endtask

  task automatic test_reset();
    in_valid_a = 0; in_valid_b = 0; flush_a = 0; flush_b = 0;
    kind = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready_a); end
    n_cmp++; if (mem_we_a !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b, required 0", mem_we_a); end
    n_cmp++; if (mem_addr_a !== BASE_A) begin n_bad++; $display("FAIL rst_mem_addr_a: got %h, required %h", mem_addr_a, BASE_A); end
    n_cmp++; if (mem_addr_b !== BASE_B) begin n_bad++; $display("FAIL rst_mem_addr_b: got %h, required %h", mem_addr_b, BASE_B); end
    n_cmp++; if (mem_wdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h, required 0", mem_wdata_a); end
    n_cmp++; if (count_a !== 9'd0) begin n_bad++; $display("FAIL rst_count: got %0d, required 0", count_a); end
    n_cmp++; if (full_a !== 1'b0 || err_a !== 1'b0) begin n_bad++; $display("FAIL rst_full_err: got %b%b, required 00", full_a, err_a); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin n_bad++; $display("FAIL ready_after_rst: got %b%b, required 11", in_ready_a, in_ready_b); end
  endtask

  task automatic test_r_type();
    send(0, KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1);
    drain(0);
  endtask

  task automatic test_back_to_back();
    send(0, KIND_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8, 32'h00812283, 1);
    send(0, KIND_STORE, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd12, 32'h00512623, 1);
    send(0, KIND_STORE, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFF_FFFC, 32'hFE512E23, 1);
    drain(0);
  endtask

  task automatic test_branch_jump_upper();
    send(0, KIND_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFF8, 32'hFE208CE3, 1);
    send(0, KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd16, 32'h010000EF, 1);
    send(0, KIND_LUI, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123453B7, 1);
    drain(0);
  endtask

  task automatic test_shift_jalr();
    send(0, KIND_OPIMM, 5'd4, 5'd4, 5'd0, 3'b101, 7'b0100000, 32'd3, 32'h40325213, 1);
    send(0, KIND_JALR, 5'd1, 5'd5, 5'd0, 3'b111, 7'd0, 32'd4, 32'h004280E7, 1);
    drain(0);
  endtask

  task automatic test_imm_range();
`ifdef ENC_IMM_CHECK_EN
    send(0, KIND_OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h0, 0);
    n_cmp++; if (err_a !== 1'b1 || mem_we_a !== 1'b0) begin n_bad++; $display("FAIL imm_reject: err=%b we=%b, required err=1 we=0", err_a, mem_we_a); end
    @(posedge clk); #1;
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width: got %b, required 0", err_a); end
    n_cmp++; if (count_a !== 9'(exp_cnt_a) || in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reject_state: count=%0d ready=%b, required %0d 1", count_a, in_ready_a, exp_cnt_a); end
`else
    send(0, KIND_OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h80000093, 1);
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL err_tied: got %b, required 0", err_a); end
    drain(0);
`endif
  endtask

  task automatic test_flush();
    // flush and a request together: flush wins, nothing is accepted
    kind = KIND_R; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7 = 7'd0;
    in_valid_a = 1'b1; flush_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; flush_a = 1'b0;
    exp_cnt_a = 0;
    n_cmp++; if (count_a !== 9'd0 || in_ready_a !== 1'b1) begin n_bad++; $display("FAIL flush_priority: count=%0d ready=%b, required 0 1", count_a, in_ready_a); end
    send(0, KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1);
    drain(0);
    // flush during WRITE: the write at 0x4 completes, then the pointer restarts
    send(0, KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1);
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    exp_cnt_a = 0;
    n_cmp++; if (count_a !== 9'd0) begin n_bad++; $display("FAIL flush_in_write: count=%0d, required 0", count_a); end
    send(0, KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd16, 32'h010000EF, 1);
    drain(0);
  endtask

  task automatic test_full();
    send(1, KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1);
    send(1, KIND_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8, 32'h00812283, 1);
    drain(1);
    n_cmp++; if (full_b !== 1'b1 || in_ready_b !== 1'b0 || err_b !== 1'b0) begin n_bad++; $display("FAIL full_state: full=%b ready=%b err=%b, required 1 0 0", full_b, in_ready_b, err_b); end
    in_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    n_cmp++; if (count_b !== 2'd2 || full_b !== 1'b1) begin n_bad++; $display("FAIL full_hold: count=%0d full=%b, required 2 1", count_b, full_b); end
    flush_b = 1'b1;
    @(posedge clk); #1;
    flush_b = 1'b0;
    exp_cnt_b = 0;
    n_cmp++; if (count_b !== 2'd0 || full_b !== 1'b0 || in_ready_b !== 1'b1) begin n_bad++; $display("FAIL full_flush: count=%0d full=%b ready=%b, required 0 0 1", count_b, full_b, in_ready_b); end
    send(1, KIND_LUI, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123453B7, 1);
    drain(1);
  endtask

  task automatic test_reset_mid_write();
    send(0, KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 0);
    n_cmp++; if (mem_we_a !== 1'b1) begin n_bad++; $display("FAIL write_before_rst: we=%b, required 1", mem_we_a); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we_a !== 1'b0 || count_a !== 9'd0) begin n_bad++; $display("FAIL rst_drops_write: we=%b count=%0d, required 0 0", mem_we_a, count_a); end
    n_cmp++; if (mem_addr_a !== BASE_A || mem_wdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_mid_outputs: addr=%h data=%h, required %h 0", mem_addr_a, mem_wdata_a, BASE_A); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL ready_after_mid_rst: got %b, required 1", in_ready_a); end
    send(0, KIND_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8, 32'h00812283, 1);
    drain(0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_r_type();
    test_back_to_back();
    test_branch_jump_upper();
    test_shift_jalr();
    test_imm_range();
    test_flush();
    test_full();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder
Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte address of the first instruction word written.
REQ-002 SHALL have parameter DEPTH, default 256, capacity in 32-bit words.
REQ-003 SHALL have clk input 1: the single clock; all state on rising edge.
REQ-004 SHALL have rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have in_valid input 1: request holds a valid instruction description.
REQ-006 SHALL have in_ready output 1: encoder accepts a request this cycle.
REQ-007 SHALL have kind input 3: 0 R, 1 LOAD, 2 OPIMM, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 JALR.
REQ-008 SHALL have rd input 5: destination register.
REQ-009 SHALL have rs1 input 5: first source register.
REQ-010 SHALL have rs2 input 5: second source register.
REQ-011 SHALL have funct3 input 3; funct7 input 7: function fields.
REQ-012 SHALL have imm input 32: signed byte immediate; for LUI, the full 32-bit upper value.
REQ-013 SHALL have flush input 1: synchronous restart of the write pointer.
REQ-014 SHALL have mem_we output 1, mem_addr output 32, mem_wdata output 32: instruction-memory write port.
REQ-015 SHALL have full output 1: DEPTH words have been written.
REQ-016 SHALL have count output $clog2(DEPTH+1): number of words written.
REQ-017 SHALL have err output 1: one-cycle pulse when a request is rejected.
Function
REQ-018 SHALL implement FSM states IDLE, WRITE, FULL. in_ready is 1 only in IDLE.
REQ-019 SHALL, on in_valid&&in_ready, register the encoded word and go to WRITE; all inputs are sampled in that cycle only.
REQ-020 SHALL, in WRITE, assert mem_we for exactly one cycle with mem_addr=BASE_ADDR+4*count, then increment count.
- Next state is FULL if the new count==DEPTH, else IDLE.
- Maximum throughput: one word per 2 cycles.
REQ-021 SHALL encode opcodes as R 0110011, LOAD 0000011, OPIMM 0010011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111, JALR 1100111.
REQ-022 SHALL encode fields as follows:
- R: funct7|rs2|rs1|funct3|rd|op.
- LOAD, OPIMM, JALR: imm[11:0]|rs1|funct3|rd|op, with funct3 forced to 000 for JALR.
- OPIMM with funct3 001 or 101: bits 31:25=funct7, bits 24:20=imm[4:0].
REQ-023 SHALL encode STORE as imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
REQ-024 SHALL encode BRANCH as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
REQ-025 SHALL encode JAL as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op, and LUI as imm[31:12]|rd|op.
REQ-026 SHALL, in FULL, hold in_ready=0 and full=1 until flush or rst.
REQ-027 SHALL, on flush, set count=0 and go to IDLE from any state.
- A flush coinciding with WRITE still completes that write, then count=0.
- flush has priority over acceptance in IDLE.
Reset
REQ-028 SHALL, while rst=1, force state IDLE, count=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, full=0, err=0, in_ready=0.
- A write in progress at reset SHALL be dropped.
REQ-029 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
Configuration
REQ-030 SHALL, with ENC_IMM_CHECK_EN defined, reject out-of-range immediates: pulse err the cycle after acceptance, perform no write, leave count unchanged, return to IDLE. Range rules:
- I/S: imm[31:11] uniform.
- B: imm[31:12] uniform and imm[0]=0.
- J: imm[31:20] uniform and imm[0]=0.
- U: imm[11:0]=0.
REQ-031 SHALL, without ENC_IMM_CHECK_EN, truncate immediates silently and tie err to 0.
Structure
REQ-032 SHALL place the kind enumeration and the 7-bit opcode constants in shared package rv_isa_pkg.
REQ-033 SHALL isolate field packing in a combinational sub-module instr_pack (kind, fields -> word, imm_bad).
Verification
REQ-034 Reset, then add x3,x1,x2 (R, f3 0, f7 0) -> mem_we one cycle, mem_addr 0x0, mem_wdata 0x002081B3, count 1.
REQ-035 lw x5,8(x2); sw x5,12(x2) back-to-back -> 0x00812283 @0x4, 0x00512623 @0x8; in_ready low on each WRITE cycle.
REQ-036 beq x1,x2,-8; jal x1,16; lui x7,0x12345000 -> 0xFE208CE3, 0x010000EF, 0x123453B7.
REQ-037 DEPTH=2: two requests -> full=1, in_ready=0, third in_valid ignored; flush -> count 0, next write @BASE_ADDR.
REQ-038 With ENC_IMM_CHECK_EN, addi imm=2048 -> err pulse, no mem_we, count unchanged; rst asserted during WRITE -> mem_we drops, count 0.
